// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / halt sequencer.
// The FSM state encoding, the default drain length and the hard-wired zero register live here.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int DRAIN_CYCLES_DEF = 4;
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencer (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_waddr;
   logic             mem_branch;
   logic             mem_zero_flag;
   logic             mem_jump;
   logic             halt_req;
   logic             cnt_clr;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_waddr,
             mem_branch, mem_zero_flag, mem_jump, halt_req, cnt_clr,
      input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_waddr,
             mem_branch, mem_zero_flag, mem_jump, halt_req, cnt_clr,
      output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: the EX-stage load writes a register the ID instruction needs next cycle,
// which EX forwarding cannot cover. Writes to $0 never create a dependency.
module pipeline_hazard_ctrl_load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_waddr,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = (ex_waddr == id_rs);
   assign rt_hit   = id_uses_rt && (ex_waddr == id_rt);
   assign load_use = ex_mem_read && (ex_waddr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: load-use bubbles, wrong-path flushes
// on MEM-resolved redirects, a debug drain-then-park FSM and saturating event counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 arst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t        state_reg, state_next;
   logic [DW-1:0] drain_reg, drain_next;
   logic          load_use;
   logic          redirect;
   logic          pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
   logic          stall_inc, flush_inc, drain_dec;
   logic [1:0]    cnt_inc;

   pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
      .id_rs       (hz.id_rs),
      .id_rt       (hz.id_rt),
      .id_uses_rt  (hz.id_uses_rt),
      .ex_mem_read (hz.ex_mem_read),
      .ex_waddr    (hz.ex_waddr),
      .load_use    (load_use)
   );

   assign redirect = hz.mem_jump || (hz.mem_branch && hz.mem_zero_flag);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg <= RUN;
         drain_reg <= '0;
      end else begin
         state_reg <= state_next;
         drain_reg <= drain_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      drain_next  = drain_reg;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      drain_dec   = 1'b0;
      if (hz.enable) begin
         case (state_reg)
            RUN: begin
               if (redirect) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else if (load_use) begin
                  idex_flush  = 1'b1;
                  stall_inc   = 1'b1;
               end else begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
               end
               if (hz.halt_req) begin
                  state_next = DRAIN;
                  drain_next = DW'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               // IF is frozen and feeds bubbles; a redirect still lets pc capture its target.
               if (redirect) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
                  drain_dec   = 1'b1;
               end else if (load_use) begin
                  idex_flush  = 1'b1;
                  stall_inc   = 1'b1;
               end else begin
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  drain_dec   = 1'b1;
               end
               if (drain_dec) begin
                  drain_next = (drain_reg == '0) ? '0 : drain_reg - DW'(1);
                  if (drain_reg <= DW'(1)) begin
                     state_next = HALTED;
                  end
               end
            end
            HALTED: begin
               if (!hz.halt_req) begin
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign cnt_inc = {flush_inc, stall_inc};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge arst) begin
         if (arst) begin
            cnt_reg <= '0;
         end else if (hz.cnt_clr) begin
            cnt_reg <= '0;
         end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign hz.stall_cnt   = g_cnt[0].cnt_reg;
   assign hz.flush_cnt   = g_cnt[1].cnt_reg;
   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_flush  = idex_flush;
   assign hz.exmem_flush = exmem_flush;
   assign hz.halted      = (state_reg == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hand-computed expectations checked with immediate assertions.
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic arst;
   int   checks;
   int   failures;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();

   pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(4)) dut (
      .clk  (clk),
      .arst (arst),
      .hz   (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare every control output in one line-item per signal.
   task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                          input logic f_ifid, input logic f_idex, input logic f_exmem,
                          input logic hlt);
      chk({tag, ".pc_en"},       32'(hz.pc_en),       32'(pc));
      chk({tag, ".ifid_en"},     32'(hz.ifid_en),     32'(ifid));
      chk({tag, ".ifid_flush"},  32'(hz.ifid_flush),  32'(f_ifid));
      chk({tag, ".idex_flush"},  32'(hz.idex_flush),  32'(f_idex));
      chk({tag, ".exmem_flush"}, 32'(hz.exmem_flush), 32'(f_exmem));
      chk({tag, ".halted"},      32'(hz.halted),      32'(hlt));
   endtask

   task automatic chk_cnt(input string tag, input int st, input int fl);
      chk({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(st));
      chk({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(fl));
   endtask

   task automatic clear_ins();
      hz.id_rs         = 5'd0;
      hz.id_rt         = 5'd0;
      hz.id_uses_rt    = 1'b0;
      hz.ex_mem_read   = 1'b0;
      hz.ex_waddr      = 5'd0;
      hz.mem_branch    = 1'b0;
      hz.mem_zero_flag = 1'b0;
      hz.mem_jump      = 1'b0;
      hz.cnt_clr       = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] waddr, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt);
      hz.ex_mem_read = 1'b1;
      hz.ex_waddr    = waddr;
      hz.id_rs       = rs;
      hz.id_rt       = rt;
      hz.id_uses_rt  = uses_rt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      arst     = 1'b1;
      hz.enable   = 1'b1;
      hz.halt_req = 1'b0;
      clear_ins();
      #1;
      chk_ctl("reset", 1, 1, 0, 0, 0, 0);
      chk_cnt("reset", 0, 0);
      #2 arst = 1'b0;
      tick();

      // lw $0 then use of $0: no dependency
      set_lu(5'd0, 5'd0, 5'd0, 1'b1);
      #1 chk_ctl("lw_r0", 1, 1, 0, 0, 0, 0);
      tick();
      clear_ins();
      #1 chk_cnt("lw_r0", 0, 0);

      // lw $2 ; add $3,$2,$4 -> one bubble
      set_lu(5'd2, 5'd2, 5'd4, 1'b1);
      #1 chk_ctl("lu_rs", 0, 0, 0, 1, 0, 0);
      tick();
      clear_ins();
      #1 chk_ctl("lu_rs_after", 1, 1, 0, 0, 0, 0);
      chk_cnt("lu_rs", 1, 0);

      // dependency only through Rt
      set_lu(5'd7, 5'd5, 5'd7, 1'b1);
      #1 chk_ctl("lu_rt", 0, 0, 0, 1, 0, 0);
      tick();
      set_lu(5'd7, 5'd5, 5'd7, 1'b0);
      #1 chk_ctl("rt_unused", 1, 1, 0, 0, 0, 0);
      tick();
      clear_ins();
      #1 chk_cnt("lu_rt", 2, 0);

      // beq taken
      hz.mem_branch = 1'b1; hz.mem_zero_flag = 1'b1;
      #1 chk_ctl("beq_taken", 1, 1, 1, 1, 1, 0);
      tick();
      hz.mem_zero_flag = 1'b0;
      #1 chk_ctl("beq_not_taken", 1, 1, 0, 0, 0, 0);
      chk_cnt("beq_taken", 2, 1);
      tick();
      clear_ins();
      #1 chk_cnt("beq_not_taken", 2, 1);

      // jump
      hz.mem_jump = 1'b1;
      #1 chk_ctl("jump", 1, 1, 1, 1, 1, 0);
      tick();
      clear_ins();
      #1 chk_cnt("jump", 2, 2);

      // load_use together with redirect: redirect wins
      set_lu(5'd3, 5'd3, 5'd0, 1'b0);
      hz.mem_jump = 1'b1;
      #1 chk_ctl("lu_and_jump", 1, 1, 1, 1, 1, 0);
      tick();
      clear_ins();
      #1 chk_cnt("lu_and_jump", 2, 3);

      // enable low: everything frozen
      hz.enable = 1'b0;
      set_lu(5'd3, 5'd3, 5'd0, 1'b0);
      #1 chk_ctl("disabled", 0, 0, 0, 0, 0, 0);
      tick();
      hz.enable = 1'b1;
      clear_ins();
      #1 chk_cnt("disabled", 2, 3);

      // halt: 4 drain cycles, then parked
      hz.halt_req = 1'b1;
      #1 chk_ctl("halt_req_run", 1, 1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("drain%0d", i), 0, 1, 1, 0, 0, 0);
         tick();
      end
      chk_ctl("halted", 0, 0, 0, 0, 0, 1);
      tick();
      chk_ctl("halted_hold", 0, 0, 0, 0, 0, 1);
      hz.halt_req = 1'b0;
      #1 chk_ctl("halted_pre_release", 0, 0, 0, 0, 0, 1);
      tick();
      chk_ctl("resumed", 1, 1, 0, 0, 0, 0);

      // drain with a stall, a redirect and an ignored halt_req drop
      hz.halt_req = 1'b1;
      tick();
      hz.halt_req = 1'b0;
      set_lu(5'd9, 5'd9, 5'd0, 1'b0);
      #1 chk_ctl("drain_lu", 0, 0, 0, 1, 0, 0);
      tick();
      clear_ins();
      hz.mem_jump = 1'b1;
      #1 chk_ctl("drain_jump", 1, 1, 1, 1, 1, 0);
      chk_cnt("drain_lu", 3, 3);
      tick();
      clear_ins();
      #1 chk_cnt("drain_jump", 3, 4);
      for (int i = 0; i < 3; i++) begin
         chk_ctl($sformatf("drain_b%0d", i), 0, 1, 1, 0, 0, 0);
         tick();
      end
      chk_ctl("halted_b", 0, 0, 0, 0, 0, 1);
      tick();
      chk_ctl("resumed_b", 1, 1, 0, 0, 0, 0);

      // async reset mid-drain
      hz.halt_req = 1'b1;
      tick();
      tick();
      hz.halt_req = 1'b0;
      #1 chk_ctl("pre_arst_drain", 0, 1, 1, 0, 0, 0);
      #1 arst = 1'b1;
      #1 chk_ctl("arst_drain", 1, 1, 0, 0, 0, 0);
      chk_cnt("arst_drain", 0, 0);
      #1 arst = 1'b0;
      tick();
      chk_ctl("post_arst", 1, 1, 0, 0, 0, 0);

      // stall counter saturation and clear priority
      set_lu(5'd4, 5'd4, 5'd0, 1'b0);
      repeat (65535) @(posedge clk);
      #1 chk_cnt("sat_full", 65535, 0);
      tick();
      chk_cnt("sat_hold", 65535, 0);
      hz.cnt_clr = 1'b1;
      tick();
      chk_cnt("clr_vs_stall", 0, 0);
      hz.cnt_clr = 1'b0;
      tick();
      chk_cnt("after_clr", 1, 0);
      clear_ins();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
